// File: rtl/xbi_xbar_sched.sv
// Crossbar-side dequeue scheduler: requests a path for the head packet, then streams it out.
// Optional request timeout is built when XBI_XBAR_SCHED_TIMEOUT_EN is defined.
module xbi_xbar_sched #(
  parameter int VC0_WORDS     = 12,
  parameter int VC1_WORDS     = 64,
  parameter int VC2_WORDS     = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk_xbar,
  input  logic        rst_xbar,
  input  logic [15:0] i_xbi_in_data,
  input  logic [2:0]  i_xbi_in_empty,
  output logic [2:0]  o_xbi_in_deq,
  output logic [5:0]  o_xbi_in_offset,
  output logic        o_xbi_in_eop,
  output logic        o_req,
  output logic [2:0]  o_req_vc,
  output logic [11:0] o_req_dst,
  input  logic        i_gnt,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_release
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOOK   = 2'd1,
    ST_REQ    = 2'd2,
    ST_BURST  = 2'd3
  } state_e;

  localparam logic [5:0] VC0_LAST    = 6'(VC0_WORDS - 1);
  localparam logic [5:0] VC1_LAST    = 6'(VC1_WORDS - 1);
  localparam logic [5:0] VC2_LAST    = 6'(VC2_WORDS - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  function automatic logic [5:0] last_offset(input logic [2:0] vc);
    logic [5:0] r;
    case (vc)
      3'b010:  r = VC1_LAST;
      3'b100:  r = VC2_LAST;
      default: r = VC0_LAST;
    endcase
    return r;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    logic r;
    case (v)
      3'b001, 3'b010, 3'b100: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  state_e      state_q;
  logic [7:0]  settle_q;
  logic        req_q;
  logic [2:0]  req_vc_q;
  logic [11:0] req_dst_q;
  logic [2:0]  deq_q;
  logic [5:0]  off_q;
  logic        eop_q;
  logic [2:0]  p1_q, p2_q, p3_q;
  logic        rel_q;
  logic        hdr_ok_s;
  logic [5:0]  off_nxt_s;
  logic        unused_s;

  // The empty flags are already reflected in the header VC field, so they are not consulted.
`ifdef XBI_XBAR_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q;
  assign unused_s = ^i_xbi_in_empty;
`else
  assign unused_s = ^{i_xbi_in_empty, 8'(TIMEOUT)};
`endif

  assign hdr_ok_s  = !i_xbi_in_data[15] && is_onehot3(i_xbi_in_data[14:12]);
  assign off_nxt_s = off_q + 6'd1;

  // Scheduler FSM plus the {active, first, last} delay line feeding the packet outputs.
  always_ff @(posedge clk_xbar or posedge rst_xbar) begin
    if (rst_xbar) begin
      state_q   <= ST_SETTLE;
      settle_q  <= SETTLE_LOAD;
      req_q     <= 1'b0;
      req_vc_q  <= 3'b000;
      req_dst_q <= 12'h000;
      deq_q     <= 3'b000;
      off_q     <= 6'd0;
      eop_q     <= 1'b0;
      p1_q      <= 3'b000;
      p2_q      <= 3'b000;
      p3_q      <= 3'b000;
      rel_q     <= 1'b0;
`ifdef XBI_XBAR_SCHED_TIMEOUT_EN
      tmo_q     <= 8'd0;
`endif
    end else begin
      p1_q  <= {(deq_q != 3'b000), (deq_q != 3'b000) && (off_q == 6'd0), eop_q};
      p2_q  <= p1_q;
      p3_q  <= p2_q;
      rel_q <= p2_q[2] & p2_q[0];
      case (state_q)
        ST_SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q <= ST_LOOK;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        ST_LOOK: begin
          if (hdr_ok_s) begin
            req_vc_q  <= i_xbi_in_data[14:12];
            req_dst_q <= i_xbi_in_data[11:0];
            req_q     <= 1'b1;
            state_q   <= ST_REQ;
`ifdef XBI_XBAR_SCHED_TIMEOUT_EN
            tmo_q     <= 8'd0;
`endif
          end
        end
        ST_REQ: begin
          // A grant arriving together with the timeout still wins.
          if (i_gnt) begin
            req_q   <= 1'b0;
            deq_q   <= req_vc_q;
            off_q   <= 6'd0;
            eop_q   <= (last_offset(req_vc_q) == 6'd0);
            state_q <= ST_BURST;
`ifdef XBI_XBAR_SCHED_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            req_q    <= 1'b0;
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
`endif
          end
        end
        ST_BURST: begin
          if (eop_q) begin
            deq_q    <= 3'b000;
            off_q    <= 6'd0;
            eop_q    <= 1'b0;
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end else begin
            off_q <= off_nxt_s;
            eop_q <= (off_nxt_s == last_offset(req_vc_q));
          end
        end
        default: begin
          state_q  <= ST_SETTLE;
          settle_q <= SETTLE_LOAD;
          req_q    <= 1'b0;
          deq_q    <= 3'b000;
          eop_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_xbi_in_deq    = deq_q;
  assign o_xbi_in_offset = off_q;
  assign o_xbi_in_eop    = eop_q;
  assign o_req           = req_q;
  assign o_req_vc        = req_vc_q;
  assign o_req_dst       = req_dst_q;
  assign o_data          = i_xbi_in_data;
  assign o_valid         = p3_q[2];
  assign o_sop           = p3_q[1];
  assign o_eop           = p3_q[0];
  assign o_release       = rel_q;

endmodule
